// File: rtl/rv32_pkg.sv
// Shared types and helpers for the iterative divide sequencer.
package rv32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } div_state_t;

    // DIV and REM work on two's-complement operands.
    function automatic logic is_signed_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // DIV and DIVU return the quotient, REM and REMU the remainder.
    function automatic logic is_quot_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Magnitude of a value, only when it is treated as signed.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic en);
        return (en && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/divide_sequencer_if.sv
// Request/response bundle between the pipeline and the divide sequencer.
interface divide_sequencer_if;
    import rv32_pkg::*;

    logic                start_valid;
    logic                start_ready;
    div_op_t             op;
    logic [XLEN-1:0]     dividend;
    logic [XLEN-1:0]     divisor;
    logic [4:0]          rd_in;
    logic                flush;
    logic                busy;
    logic                result_valid;
    logic                result_ready;
    logic [XLEN-1:0]     result;
    logic [4:0]          rd_out;

    // Pipeline side: issues requests and consumes results.
    modport master (
        output start_valid, op, dividend, divisor, rd_in, flush, result_ready,
        input  start_ready, busy, result_valid, result, rd_out
    );

    // Divider side.
    modport slave (
        input  start_valid, op, dividend, divisor, rd_in, flush, result_ready,
        output start_ready, busy, result_valid, result, rd_out
    );

endinterface

// File: rtl/divide_sequencer_div_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, trial
// subtract, keep the difference when it does not go negative.
module div_step
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    // Trial subtraction on a 33-bit partial remainder; bit 32 of the
    // difference is set exactly when the shifted remainder is below the divisor.
    always_comb begin
        w_shifted = {i_rem, i_quo[XLEN-1]};
        w_diff    = w_shifted - {1'b0, i_divisor};
        if (w_diff[XLEN]) begin
            o_rem = w_shifted[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end else begin
            o_rem = w_diff[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divide_sequencer.sv
// Multi-cycle RV32 divide/remainder unit: magnitudes in, 32 restoring steps,
// sign fix-up, result held until the consumer takes it.
module divide_sequencer
    import rv32_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    divide_sequencer_if.slave   bus
);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [4:0]       r_count;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_divisor;
    logic [XLEN-1:0]  r_result;
    div_op_t          r_op;
    logic [4:0]       r_rd;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_accept;
    logic             w_signed;
    logic             w_div_zero;
    logic             w_overflow;
    logic [XLEN-1:0]  w_step_rem;
    logic [XLEN-1:0]  w_step_quo;
    logic [XLEN-1:0]  w_fix_quo;
    logic [XLEN-1:0]  w_fix_rem;

    assign w_accept   = bus.start_valid && bus.start_ready;
    assign w_signed   = is_signed_op(bus.op);
    assign w_div_zero = (bus.divisor == '0);
    assign w_overflow = w_signed && (bus.dividend == 32'h8000_0000)
                                 && (bus.divisor  == 32'hFFFF_FFFF);

    div_step u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Sign correction of the unsigned quotient and remainder.
    always_comb begin
        w_fix_quo = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_fix_rem = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic; flush overrides everything, including a DONE handshake.
    always_comb begin
        // NOTE: the default assignment up front keeps this block free of latches.
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept)
                             w_next_state = (w_div_zero || w_overflow) ? S_DONE : S_RUN;
                S_RUN:   if (r_count == 5'd0) w_next_state = S_FIXUP;
                S_FIXUP: w_next_state = S_DONE;
                S_DONE:  if (bus.result_ready) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; result and rd_out read as zero outside DONE.
    always_comb begin
        bus.start_ready  = (r_state == S_IDLE) && !bus.flush;
        bus.busy         = (r_state != S_IDLE);
        bus.result_valid = (r_state == S_DONE);
        bus.result       = (r_state == S_DONE) ? r_result : '0;
        bus.rd_out       = (r_state == S_DONE) ? r_rd : '0;
    end

    // Datapath: latch operands on accept, iterate in RUN, fix up once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= 5'd0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_op      <= OP_DIV;
            r_rd      <= 5'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (w_accept) begin
            r_op      <= bus.op;
            r_rd      <= bus.rd_in;
            r_neg_q   <= w_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
            r_neg_r   <= w_signed && bus.dividend[XLEN-1];
            r_quo     <= abs_val(bus.dividend, w_signed);
            r_divisor <= abs_val(bus.divisor, w_signed);
            r_rem     <= '0;
            r_count   <= 5'd31;
            // Special cases skip the iteration, so their result is final here.
            if (w_div_zero)
                r_result <= is_quot_op(bus.op) ? 32'hFFFF_FFFF : bus.dividend;
            else if (w_overflow)
                r_result <= is_quot_op(bus.op) ? 32'h8000_0000 : 32'h0;
            else
                r_result <= '0;
        end else if (r_state == S_RUN) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            if (r_count != 5'd0) r_count <= r_count - 5'd1;
        end else if (r_state == S_FIXUP) begin
            r_result <= is_quot_op(r_op) ? w_fix_quo : w_fix_rem;
        end
    end

endmodule

// File: tb/tb_divide_sequencer.sv
// Directed and random checks of divide_sequencer against a behavioural
// divide model, with a scoreboard of expected results.
module tb_divide_sequencer;
    import rv32_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    exp_t sb[$];

    divide_sequencer_if bus();

    divide_sequencer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural RV32M reference, written from the ISA rules.
    function automatic logic [31:0] model(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic s;
        logic q;
        s = (op == OP_DIV) || (op == OP_REM);
        q = (op == OP_DIV) || (op == OP_DIVU);
        if (b == 32'h0) return q ? 32'hFFFF_FFFF : a;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return q ? 32'h8000_0000 : 32'h0;
        if (s) return q ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
        return q ? a / b : a % b;
    endfunction

    function automatic int model_lat(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = (op == OP_DIV) || (op == OP_REM);
        if (b == 32'h0) return 1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one request, wait for its result, hold it for 'hold' cycles, then take it.
    task automatic do_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold);
        exp_t e;
        int   cyc;
        e.res = model(op, a, b);
        e.rd  = rd;
        e.lat = model_lat(op, a, b);
        bus.op = op; bus.dividend = a; bus.divisor = b; bus.rd_in = rd;
        bus.start_valid = 1'b1;
        check("start_ready_idle", 32'(bus.start_ready), 32'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        cyc = 1;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        while (!bus.result_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        check("result_valid_seen", 32'(bus.result_valid), 32'd1);
        check("latency", 32'(cyc), 32'(e.lat));
        check("result", bus.result, e.res);
        check("rd_out", 32'(bus.rd_out), 32'(e.rd));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_result", bus.result, e.res);
            check("hold_rd_out", 32'(bus.rd_out), 32'(e.rd));
            check("hold_busy", 32'(bus.busy), 32'd1);
            check("hold_valid", 32'(bus.result_valid), 32'd1);
            check("hold_start_ready", 32'(bus.start_ready), 32'd0);
        end
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        check("idle_valid", 32'(bus.result_valid), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_result_zero", bus.result, 32'h0);
        check("idle_start_ready", 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        int seen;
        checks = 0;
        failures = 0;
        resetn = 1'b0;
        bus.start_valid = 1'b0; bus.op = OP_DIV; bus.dividend = '0; bus.divisor = '0;
        bus.rd_in = '0; bus.flush = 1'b0; bus.result_ready = 1'b0;

        // Reset state.
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_rd_out", 32'(bus.rd_out), 32'd0);
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Basic unsigned and signed cases.
        do_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 0);
        do_op(OP_REMU, 32'd100, 32'd7, 5'd4, 0);
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 0);

        // Divide by zero and signed overflow bypasses.
        do_op(OP_DIV,  32'd5, 32'd0, 5'd7, 0);
        do_op(OP_REMU, 32'd5, 32'd0, 5'd8, 0);
        do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);

        // Back-pressure: result held for 5 cycles.
        do_op(OP_DIVU, 32'd1000, 32'd10, 5'd17, 5);

        // Flush at RUN cycle 10.
        bus.op = OP_DIVU; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.rd_in = 5'd12;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_run_busy", 32'(bus.busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.result_valid) seen = 1;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        do_op(OP_DIVU, 32'd9, 32'd3, 5'd13, 0);

        // Flush concurrent with a request accepts nothing.
        bus.op = OP_DIVU; bus.dividend = 32'd9; bus.divisor = 32'd3;
        bus.start_valid = 1'b1; bus.flush = 1'b1;
        #1 check("flush_start_ready", 32'(bus.start_ready), 32'd0);
        @(posedge clk); #1;
        bus.start_valid = 1'b0; bus.flush = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'd0);

        // Flush in DONE together with result_ready.
        bus.op = OP_DIV; bus.dividend = 32'd5; bus.divisor = 32'd0; bus.rd_in = 5'd9;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        check("flush_done_valid_before", 32'(bus.result_valid), 32'd1);
        bus.flush = 1'b1; bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.result_ready = 1'b0;
        check("flush_done_valid_after", 32'(bus.result_valid), 32'd0);
        check("flush_done_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-RUN.
        bus.op = OP_DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.rd_in = 5'd21;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_valid", 32'(bus.result_valid), 32'd0);
        check("mid_rst_result", bus.result, 32'h0);
        check("mid_rst_rd_out", 32'(bus.rd_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // A few random operands after recovery.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_op(div_op_t'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divide_sequencer.md
DIVIDE_SEQUENCER -- requirements
Module: divide_sequencer

Interface
REQ-001 The block SHALL have one clock, clk (input, 1): all state updates on its rising edge.
REQ-002 The block SHALL have resetn (input, 1): reset is asynchronous and active-low.
REQ-003 The block SHALL have start_valid (input, 1): a divide request is presented.
REQ-004 The block SHALL have start_ready (output, 1): a request is accepted when start_valid && start_ready.
REQ-005 The block SHALL have op (input, div_op_t, 2): DIV=00, DIVU=01, REM=10, REMU=11.
REQ-006 The block SHALL have dividend (input, 32) = rs1 value and divisor (input, 32) = rs2 value.
REQ-007 The block SHALL have rd_in (input, 5): destination register, returned with the result.
REQ-008 The block SHALL have flush (input, 1): abandon any in-flight operation.
REQ-009 The block SHALL have busy (output, 1): pipeline stall request, high in every state other than IDLE.
REQ-010 The block SHALL have result_valid (output, 1), result_ready (input, 1), result (output, 32) and rd_out (output, 5).

Function
REQ-011 States SHALL be IDLE, RUN, FIXUP and DONE.
REQ-012 start_ready SHALL equal (state==IDLE) && !flush.
REQ-013 On accept, op, rd_in, |dividend|, |divisor| and the sign flags SHALL be latched.
  - Absolute values are taken for signed ops only.
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
REQ-014 Normal path: IDLE->RUN on accept, then 32 RUN cycles (restoring radix-2, one quotient bit per cycle, 5-bit down-counter 31..0), then RUN->FIXUP when the counter is 0.
REQ-015 FIXUP SHALL apply the sign correction, select the quotient (DIV/DIVU) or the remainder (REM/REMU), and go to DONE.
REQ-016 result_valid SHALL be high exactly in DONE.
  - Normal-path latency: result_valid rises 34 cycles after the accept edge.
REQ-017 Divisor == 0 SHALL bypass RUN/FIXUP (IDLE->DONE):
  - quotient = 32'hFFFFFFFF;
  - remainder = dividend;
  - result_valid rises 1 cycle after accept.
REQ-018 DIV/REM with dividend 32'h80000000 and divisor 32'hFFFFFFFF SHALL bypass to DONE:
  - quotient = 32'h80000000;
  - remainder = 0;
  - latency 1 cycle.
REQ-019 DONE SHALL hold result and rd_out stable until result_valid && result_ready, then go to IDLE.
  - A new request is accepted no earlier than the following cycle.
REQ-020 flush SHALL force the state to IDLE on the next edge from any state, discarding the result.
  - flush concurrent with start_valid accepts nothing.
  - flush in DONE concurrent with result_ready: flush wins; the handshake is considered not completed.
REQ-021 result and rd_out SHALL be don't-care outside DONE but driven to 0 in IDLE.
REQ-022 All internal arithmetic SHALL be 32-bit unsigned on magnitudes, with a 33-bit partial remainder for the subtract-compare.

Reset
REQ-023 While resetn is low:
  - state = IDLE and counter = 0;
  - busy = 0, result_valid = 0, result = 0, rd_out = 0;
  - start_ready = 1 once flush is low.
REQ-024 Reset asserted mid-RUN SHALL abort the operation immediately (asynchronously) with no result produced.

Structure
REQ-025 div_op_t and div_state_t SHALL be defined in rv32_pkg.
REQ-026 One combinational sub-module, div_step, SHALL implement a single restoring iteration: inputs partial remainder, quotient and divisor; outputs their next values.

Verification
REQ-027 DIVU 100 / 7:
  - result_valid at accept+34 with result 14;
  - with REMU, result 2.
REQ-028 DIV -7 / 2:
  - result = 32'hFFFFFFFD (-3);
  - REM gives 32'hFFFFFFFF (-1).
REQ-029 DIV 5 / 0 -> result 32'hFFFFFFFF at accept+1; REMU 5 / 0 -> result 5.
REQ-030 DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000; REM of the same operands -> 0; both at accept+1.
REQ-031 Back-pressure and rd_out:
  - Hold result_ready=0 for 5 cycles in DONE -> result and rd_out stable, busy=1 throughout.
  - Then result_ready=1 -> IDLE on the next cycle.
REQ-032 flush at RUN cycle 10 -> IDLE next cycle, no result_valid.
  - Request 9/3 issued next -> result 3 at accept+34.
  - Reset asserted mid-RUN -> all outputs 0 immediately.
